// File: rtl/req_event_capture_83.sv
// rtl/req_event_capture_83.sv - 8-line request synchroniser, edge capture and priority event serialiser
module req_event_capture_83 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] pending,
    output logic       overflow
);

    logic [7:0] r_sync [SYNC_STAGES];
    logic [7:0] r_sync_d;
    logic [7:0] r_rise;
    logic [7:0] r_pending;
    logic       r_valid;
    logic [2:0] r_code;
    logic       r_overflow;

    logic [7:0] w_eligible;
    logic [2:0] w_idx;
    logic       w_load;
    logic [7:0] w_load_mask;
    logic [7:0] w_pending_next;
    logic       w_overflow;

    // Edges are registered once more after detection so a new pending bit
    // appears SYNC_STAGES+1 edges after the request is first sampled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 8'h00;
            end
            r_sync_d <= 8'h00;
            r_rise   <= 8'h00;
        end else begin
            r_sync[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_rise   <= r_sync[SYNC_STAGES-1] & ~r_sync_d;
        end
    end

    assign w_eligible = r_pending & mask;

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_eligible[i]) begin
                w_idx = i[2:0];
            end
        end
    end

    assign w_load      = (~r_valid | out_ready) & (|w_eligible);
    assign w_load_mask = w_load ? (8'b0000_0001 << w_idx) : 8'h00;

    // A fresh edge on the bit being loaded re-arms it instead of being lost.
    assign w_pending_next = (r_pending & ~w_load_mask) | r_rise;
    assign w_overflow     = |(r_rise & r_pending & ~w_load_mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending  <= 8'h00;
            r_valid    <= 1'b0;
            r_code     <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_overflow <= w_overflow;
            if (w_load) begin
                r_valid <= 1'b1;
                r_code  <= w_idx;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule
